// File: rtl/fft_seq_ctrl_if.sv
// Handshake and status bundle between the input sample source and the FFT
// frame sequencer. The source side (master) offers beats and flush requests;
// the sequencer side (slave) returns ready, stage counts and output framing.
interface fft_seq_ctrl_if #(
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned NUM_STG = 3
);
  logic                     din_valid;
  logic                     flush;
  logic                     in_ready;
  logic [CNT_W-1:0]         cnt_ctrl;
  logic [NUM_STG*CNT_W-1:0] cnt_stg;
  logic                     dout_valid;
  logic                     frame_sop;
  logic                     frame_eop;
  logic [15:0]              frame_cnt;
  logic                     busy;
  logic                     done;
  logic                     err_timeout;

  modport master (
    output din_valid, flush,
    input  in_ready, cnt_ctrl, cnt_stg, dout_valid, frame_sop, frame_eop,
           frame_cnt, busy, done, err_timeout
  );

  modport slave (
    input  din_valid, flush,
    output in_ready, cnt_ctrl, cnt_stg, dout_valid, frame_sop, frame_eop,
           frame_cnt, busy, done, err_timeout
  );
endinterface

// File: rtl/fft_seq_ctrl.sv
// Frame-level sequencer for the streaming FFT datapath.
// Counts accepted input beats for stage 0, replays the accept strobe down a
// delay line to drive per-stage counts, frames the last-stage output with
// SOP/EOP, counts completed frames and recovers from gaps or flush requests.
module fft_seq_ctrl #(
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned NUM_STG   = 3,
  parameter int unsigned STAGE_LAT = 2,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic          clk,
  input  logic          rst,
  fft_seq_ctrl_if.slave bus
);

  localparam int unsigned DLY = NUM_STG * STAGE_LAT;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FLUSH
  } state_t;

  state_t                        state;
  logic [CNT_W-1:0]              cnt_ctrl_q;
  logic [NUM_STG-1:0][CNT_W-1:0] stg_q;
  logic [NUM_STG-1:0][CNT_W-1:0] stg_nxt;
  logic [NUM_STG-1:0]            stg_hit;
  logic [DLY-1:0]                dly_q;
  logic [7:0]                    idle_q;
  logic                          sop_q;
  logic                          eop_q;
  logic                          done_q;
  logic                          err_q;
  logic [15:0]                   frame_cnt_q;
  logic                          accept;
  logic                          timeout_hit;
  logic                          go_flush;

  // Beats are refused only during the single FLUSH cycle.
  assign accept      = bus.din_valid & (state != FLUSH);
  // The idle counter holds the gap length before this cycle, so a further
  // non-accept here makes the gap reach TIMEOUT.
  assign timeout_hit = (state == RUN) & ~accept & (idle_q == 8'(TIMEOUT - 1));
  assign go_flush    = bus.flush | timeout_hit;

  // Stage k sees the accept strobe (k+1)*STAGE_LAT cycles late; its next
  // count is precomputed so the last stage can frame SOP/EOP one cycle early
  // and still present them as registered outputs aligned with dout_valid.
  for (genvar k = 0; k < NUM_STG; k++) begin : g_stage
    assign stg_hit[k] = dly_q[(k + 1) * STAGE_LAT - 1];
    assign stg_nxt[k] = stg_hit[k] ? stg_q[k] + CNT_W'(1) : stg_q[k];
  end

  // Datapath: stage-0 count, accept delay line, stage counts, framing and
  // the frame counter (the latter survives flush/timeout clears).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_ctrl_q  <= '0;
      stg_q       <= '0;
      dly_q       <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (eop_q) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (go_flush) begin
        cnt_ctrl_q <= '0;
        stg_q      <= '0;
        dly_q      <= '0;
        sop_q      <= 1'b0;
        eop_q      <= 1'b0;
      end else begin
        if (accept) begin
          cnt_ctrl_q <= cnt_ctrl_q + CNT_W'(1);
        end
        stg_q <= stg_nxt;
        dly_q <= {dly_q[DLY-2:0], accept};
        sop_q <= dly_q[DLY-2] & (stg_nxt[NUM_STG-1] == '0);
        eop_q <= dly_q[DLY-2] & (stg_nxt[NUM_STG-1] == '1);
      end
    end
  end

  // Frame FSM with idle-gap counter and registered done/err_timeout pulses;
  // flush outranks timeout, which outranks normal accept handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idle_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.flush) begin
        state  <= FLUSH;
        idle_q <= '0;
      end else if (timeout_hit) begin
        state  <= FLUSH;
        idle_q <= '0;
        err_q  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            idle_q <= '0;
            if (accept) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (accept) begin
              idle_q <= '0;
              if (cnt_ctrl_q == '1) begin
                state <= DRAIN;
              end
            end else begin
              idle_q <= idle_q + 8'd1;
            end
          end
          DRAIN: begin
            idle_q <= '0;
            if (accept) begin
              state <= RUN;
            end else if (dly_q == '0) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
          FLUSH: begin
            idle_q <= '0;
            state  <= IDLE;
          end
          default: begin
            idle_q <= '0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.in_ready    = (state != FLUSH);
  assign bus.busy        = (state != IDLE);
  assign bus.cnt_ctrl    = cnt_ctrl_q;
  assign bus.cnt_stg     = stg_q;
  assign bus.dout_valid  = dly_q[DLY-1];
  assign bus.frame_sop   = sop_q;
  assign bus.frame_eop   = eop_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.done        = done_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl. The reference derives every output
// from the recorded history of accepts and clears (counts of beats since the
// last clear, beat age versus pipeline latency) rather than from FSM state.
module tb_fft_seq_ctrl;
  localparam int CW   = 5;
  localparam int NS   = 3;
  localparam int SL   = 2;
  localparam int TO   = 64;
  localparam int LAT  = NS * SL;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst;

  fft_seq_ctrl_if #(.CNT_W(CW), .NUM_STG(NS)) bif ();

  fft_seq_ctrl #(
    .CNT_W    (CW),
    .NUM_STG  (NS),
    .STAGE_LAT(SL),
    .TIMEOUT  (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // History, indexed by cycle since the last reset release.
  bit acc   [MAXC];   // beat accepted in this cycle
  bit clr   [MAXC];   // pipeline cleared at the end of this cycle
  bit tmo   [MAXC];   // that clear came from the gap timeout
  bit busyx [MAXC];   // expected busy in this cycle
  int cyc;
  int fcm;

  int obs_done, obs_err, obs_nrdy, obs_eop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int nacc(input int lo, input int hi);
    int s;
    int l;
    s = 0;
    l = (lo < 0) ? 0 : lo;
    for (int i = l; i <= hi; i++) begin
      if (i < MAXC && acc[i]) s++;
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MAXC; i++) begin
      acc[i] = 1'b0; clr[i] = 1'b0; tmo[i] = 1'b0; busyx[i] = 1'b0;
    end
    cyc = 0;
    fcm = 0;
  endtask

  task automatic clr_obs();
    obs_done = 0; obs_err = 0; obs_nrdy = 0; obs_eop = 0;
  endtask

  // One clock cycle: check outputs against the history-based expectation,
  // then drive this cycle's inputs and record what the design must do.
  task automatic step(input bit dv, input bit fl);
    int lc, la, ecnt, e3;
    logic [NS*CW-1:0] estg;
    bit fcyc, fcyc2, edv, esop, eeop, ebusy, edone, eerr, erdy;
    @(negedge clk);
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    lc = -1000;
    for (int i = cyc - 1; i >= 0; i--) if (clr[i]) begin lc = i; break; end
    la = -1000;
    for (int i = cyc - 1; i >= 0; i--) if (acc[i]) begin la = i; break; end
    fcyc  = (cyc >= 1) && clr[cyc-1];
    fcyc2 = (cyc >= 2) && clr[cyc-2];
    ecnt  = nacc(lc + 1, cyc - 1) % 32;
    for (int k = 1; k <= NS; k++) estg[k*CW-1 -: CW] = CW'(nacc(lc + 1, cyc - 1 - k*SL) % 32);
    e3    = nacc(lc + 1, cyc - 1 - LAT) % 32;
    edv   = (cyc - LAT >= 0) && (cyc - LAT > lc) && acc[(cyc - LAT >= 0) ? cyc - LAT : 0];
    esop  = edv && (e3 == 0);
    eeop  = edv && (e3 == 31);
    erdy  = !fcyc;
    eerr  = fcyc && tmo[cyc-1];
    ebusy = fcyc || (ecnt != 0) || ((la > lc) && (cyc - la <= LAT + 1));
    edone = (cyc >= 1) && busyx[cyc-1] && !ebusy && !fcyc2;

    chk("in_ready",    32'(bif.in_ready),    32'(erdy));
    chk("busy",        32'(bif.busy),        32'(ebusy));
    chk("cnt_ctrl",    32'(bif.cnt_ctrl),    32'(ecnt));
    chk("cnt_stg",     32'(bif.cnt_stg),     32'(estg));
    chk("dout_valid",  32'(bif.dout_valid),  32'(edv));
    chk("frame_sop",   32'(bif.frame_sop),   32'(esop));
    chk("frame_eop",   32'(bif.frame_eop),   32'(eeop));
    chk("frame_cnt",   32'(bif.frame_cnt),   32'(fcm & 16'hffff));
    chk("done",        32'(bif.done),        32'(edone));
    chk("err_timeout", 32'(bif.err_timeout), 32'(eerr));

    if (bif.done)        obs_done++;
    if (bif.err_timeout) obs_err++;
    if (!bif.in_ready)   obs_nrdy++;
    if (bif.frame_eop)   obs_eop++;

    bif.din_valid = dv;
    bif.flush     = fl;
    acc[cyc]   = dv && erdy;
    tmo[cyc]   = !fl && (ecnt != 0) && !acc[cyc] && (cyc - la == TO);
    clr[cyc]   = fl || tmo[cyc];
    busyx[cyc] = ebusy;
    if (eeop) fcm++;
    cyc++;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bif.din_valid = 1'b0;
    bif.flush     = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready",  32'(bif.in_ready),  32'd1);
    chk("rst_busy",      32'(bif.busy),      32'd0);
    chk("rst_cnt_ctrl",  32'(bif.cnt_ctrl),  32'd0);
    chk("rst_frame_cnt", 32'(bif.frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Single frame from IDLE.
    clr_obs();
    beats(32);
    gap(12);
    chk("f1_done_pulses", 32'(obs_done), 32'd1);
    chk("f1_eops",        32'(obs_eop),  32'd1);
    chk("f1_frame_cnt",   32'(bif.frame_cnt), 32'd1);

    // Two back-to-back frames: one done after the second.
    clr_obs();
    beats(64);
    gap(12);
    chk("f2_done_pulses", 32'(obs_done), 32'd1);
    chk("f2_eops",        32'(obs_eop),  32'd2);
    chk("f2_frame_cnt",   32'(bif.frame_cnt), 32'd3);

    // Legal 10-cycle gap after beat 7.
    clr_obs();
    beats(8);
    gap(10);
    beats(24);
    gap(12);
    chk("gap_err",       32'(obs_err), 32'd0);
    chk("gap_eops",      32'(obs_eop), 32'd1);
    chk("gap_frame_cnt", 32'(bif.frame_cnt), 32'd4);

    // 64-cycle gap after beat 5: timeout abort.
    clr_obs();
    beats(6);
    gap(64);
    gap(10);
    chk("tmo_err_pulses", 32'(obs_err),  32'd1);
    chk("tmo_not_ready",  32'(obs_nrdy), 32'd1);
    chk("tmo_eops",       32'(obs_eop),  32'd0);
    chk("tmo_done",       32'(obs_done), 32'd0);
    chk("tmo_frame_cnt",  32'(bif.frame_cnt), 32'd4);

    // Flush at beat 20, then a clean frame.
    clr_obs();
    beats(20);
    step(1'b1, 1'b1);
    gap(3);
    beats(32);
    gap(12);
    chk("fl_err",       32'(obs_err),  32'd0);
    chk("fl_not_ready", 32'(obs_nrdy), 32'd1);
    chk("fl_eops",      32'(obs_eop),  32'd1);
    chk("fl_frame_cnt", 32'(bif.frame_cnt), 32'd5);

    // Randomised traffic: bursts, sparse beats, near/over-timeout gaps, flushes.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0:       gap($urandom_range(60, 68));
        1:       step(1'($urandom_range(0, 1)), 1'b1);
        2, 3, 4: beats($urandom_range(1, 40));
        default: begin
          for (int j = 0; j < 12; j++) step($urandom_range(0, 99) < 70, 1'b0);
        end
      endcase
    end
    gap(12);

    // Asynchronous reset mid-frame, right after beat 12 is taken.
    beats(12);
    step(1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bif.din_valid = 1'b0;
    #1;
    chk("arst_in_ready",    32'(bif.in_ready),    32'd1);
    chk("arst_busy",        32'(bif.busy),        32'd0);
    chk("arst_cnt_ctrl",    32'(bif.cnt_ctrl),    32'd0);
    chk("arst_cnt_stg",     32'(bif.cnt_stg),     32'd0);
    chk("arst_dout_valid",  32'(bif.dout_valid),  32'd0);
    chk("arst_frame_cnt",   32'(bif.frame_cnt),   32'd0);
    chk("arst_done",        32'(bif.done),        32'd0);
    chk("arst_err_timeout", 32'(bif.err_timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clr_obs();
    beats(32);
    gap(12);
    chk("post_rst_eops",      32'(obs_eop),  32'd1);
    chk("post_rst_done",      32'(obs_done), 32'd1);
    chk("post_rst_frame_cnt", 32'(bif.frame_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
Frame-level sequencer for the streaming FFT datapath. It accepts input beats and generates the stage-0 butterfly/twiddle control count, plus delayed per-stage control counts for downstream pipeline stages. It also generates output-side framing (valid/SOP/EOP), a frame counter, and gap-timeout/flush recovery. It sits between the input sample interface and the FFT stage chain, and replaces free-running per-stage counters.

Parameters:
CNT_W, 5, control count width; frame length = 2^CNT_W beats (32)
NUM_STG, 3, number of downstream stages that receive a delayed count
STAGE_LAT, 2, pipeline latency in cycles of each stage
TIMEOUT, 64, consecutive non-accept cycles in RUN that trigger an abort (legal range 2..255)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, asynchronous, active-high
din_valid  in  1  input beat present
flush  in  1  synchronous abort request
in_ready  out  1  controller can accept a beat
cnt_ctrl  out  CNT_W  stage-0 control count
cnt_stg  out  NUM_STG*CNT_W  stage k count in bits [k*CNT_W-1 -: CNT_W], k=1..NUM_STG
dout_valid  out  1  output beat valid (last stage)
frame_sop  out  1  first output beat of a frame
frame_eop  out  1  last output beat of a frame
frame_cnt  out  16  completed output frames
busy  out  1  state != IDLE
done  out  1  1-cycle pulse: pipeline drained
err_timeout  out  1  1-cycle pulse: partial frame aborted

Behaviour:
- Reset (async, rst=1): state=IDLE. All counts, delay lines, frame_cnt, the idle counter, and all outputs are 0, except in_ready=1.
- accept = din_valid & in_ready. in_ready=0 only in FLUSH.
- cnt_ctrl: +1 on accept. Wraps from 2^CNT_W-1 to 0. Held otherwise.
- Delay line: v_k = accept delayed exactly k*STAGE_LAT cycles.
  - Each stage counter k increments on v_k and wraps like cnt_ctrl.
  - dout_valid = v_NUM_STG, giving a latency of 6 cycles at defaults.
- Output framing, using the last-stage count before its increment:
  - frame_sop = dout_valid & (count == 0).
  - frame_eop = dout_valid & (count == max).
  - frame_cnt +1 on frame_eop; 16-bit wrap; not cleared by flush.
- FSM (IDLE, RUN, DRAIN, FLUSH). Priority: flush > timeout > accept.
  - IDLE: accept -> RUN.
  - RUN:
    - accept with cnt_ctrl == max -> DRAIN.
    - Idle counter clears on accept and increments otherwise.
    - Idle counter reaching TIMEOUT -> FLUSH with err_timeout.
    - Gaps shorter than TIMEOUT are legal mid-frame.
  - DRAIN:
    - accept -> RUN (back-to-back frame; no done).
    - Otherwise, when the delay line is all-zero -> IDLE.
    - Timeout is not evaluated in DRAIN.
  - FLUSH: lasts exactly one cycle, then IDLE.
    - Clears cnt_ctrl, stage counts, delay line and idle counter.
    - Beats in flight are discarded; no dout_valid, SOP or EOP from them.
  - flush=1 in any state -> FLUSH next cycle. The beat offered in that cycle is still accepted, but is discarded by the clear.
- Pulses:
  - done = 1 for the first cycle in IDLE after DRAIN.
  - err_timeout = 1 for the FLUSH cycle entered by timeout; 0 for flush-initiated FLUSH.
- busy = (state != IDLE).
- Simultaneous: accept in the same cycle the DRAIN delay line empties -> RUN, and done is not asserted.
- All outputs are registered except in_ready and busy, which decode from state only.

Test Plan:
- Single frame, 32 back-to-back beats from IDLE:
  - cnt_ctrl 0..31 -> 0.
  - dout_valid is first high 6 cycles after the first accept.
  - frame_sop on output beat 0; frame_eop on beat 31.
  - frame_cnt=1; done pulses once; busy returns to 0.
- Two frames back-to-back (64 beats) -> FSM goes RUN->DRAIN->RUN with no done between frames; frame_cnt=2; exactly one done after the drain.
- Frame with a 10-cycle gap after beat 7 -> counts hold during the gap; output has an identical 10-cycle gap; no error; frame completes normally.
- Gap of 64 cycles after beat 5 -> err_timeout pulses once; in_ready=0 for 1 cycle; counts are cleared; no frame_eop; frame_cnt is unchanged.
- flush asserted at beat 20 -> FLUSH next cycle; no err_timeout; all counts 0; a fresh 32-beat frame afterwards completes with correct SOP/EOP.
- rst asserted mid-frame (beat 12), asynchronously between clock edges -> all outputs go to reset values immediately; in_ready=1; frame_cnt=0.
